// File: rtl/accum_pkg.sv
// Shared types and constants for the burst accumulator.
// State encoding and datapath width live here so every file agrees.
package accum_pkg;
  localparam int ACC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/adder_16bit.sv
// 16-bit unsigned ripple adder.
// overflow is the carry out of bit 15.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
endmodule

// File: rtl/flex_counter.sv
// Parameterised counter running 0 .. rollover_val-1.
// rollover_flag marks the last count, so an enabled step there wraps to 0.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] w_last;

  assign w_last        = rollover_val - 1'b1;
  assign rollover_flag = (r_count == w_last);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      r_count <= rollover_flag ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/accum_ctrl_16bit.sv
// Burst accumulator: sums NUM_SAMPLES samples through adder_16bit,
// then offers the total and a sticky carry flag over a handshake.
module accum_ctrl_16bit
  import accum_pkg::*;
#(
  parameter int NUM_SAMPLES = 8,
  parameter int CNT_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 sample_valid,
  input  logic [ACC_WIDTH-1:0] sample_data,
  output logic                 sample_ready,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 result_overflow,
  output logic                 busy
);
  localparam logic [CNT_BITS-1:0] ROLL = CNT_BITS'(NUM_SAMPLES);

  state_t               r_state;
  state_t               w_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 r_ovf;
  logic                 w_carry;
  logic                 w_xfer;
  logic                 w_roll;
  logic                 w_go;
  logic                 w_cnt_clr;

  assign w_xfer    = sample_valid && (r_state == ACCUM);
  assign w_go      = (r_state == IDLE) && start;
  assign w_cnt_clr = clear || w_go;

  adder_16bit u_add (
    .a        (r_acc),
    .b        (sample_data),
    .carry_in (1'b0),
    .sum      (w_sum),
    .overflow (w_carry)
  );

  flex_counter #(
    .NUM_CNT_BITS (CNT_BITS)
  ) u_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_cnt_clr),
    .count_enable  (w_xfer),
    .rollover_val  (ROLL),
    .rollover_flag (w_roll)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = ACCUM;
      ACCUM:   if (w_xfer && w_roll) w_next = DONE;
      DONE:    if (result_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // acc/ovf hold after DONE so the result survives until the next start
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (w_xfer) begin
        r_acc <= w_sum;
        r_ovf <= r_ovf | w_carry;
      end
    end
  end

  assign sample_ready    = (r_state == ACCUM);
  assign result_valid    = (r_state == DONE);
  assign busy            = (r_state == ACCUM) || (r_state == DONE);
  assign result          = r_acc;
  assign result_overflow = r_ovf;
endmodule

// File: tb/tb_accum_ctrl_16bit.sv
// Directed bench for accum_ctrl_16bit with an expected-result queue.
// A second instance is built with NUM_SAMPLES=1.
module tb_accum_ctrl_16bit;
  logic        clk;
  logic        n_rst;
  logic        clear;
  logic        start;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] result;
  logic        result_overflow;
  logic        busy;

  logic        start1;
  logic        sv1;
  logic [15:0] sd1;
  logic        sr1;
  logic        rv1;
  logic        rr1;
  logic [15:0] res1;
  logic        ovf1;
  logic        busy1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [16:0] q[$];
  logic [16:0] q1[$];
  logic [15:0] samp [0:7];

  accum_ctrl_16bit #(.NUM_SAMPLES(8), .CNT_BITS(8)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear           (clear),
    .start           (start),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .sample_ready    (sample_ready),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result          (result),
    .result_overflow (result_overflow),
    .busy            (busy)
  );

  accum_ctrl_16bit #(.NUM_SAMPLES(1), .CNT_BITS(8)) dut1 (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear           (1'b0),
    .start           (start1),
    .sample_valid    (sv1),
    .sample_data     (sd1),
    .sample_ready    (sr1),
    .result_valid    (rv1),
    .result_ready    (rr1),
    .result          (res1),
    .result_overflow (ovf1),
    .busy            (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input int n);
    logic [16:0] t;
    logic [15:0] a;
    logic        o;
    a = '0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = {1'b0, a} + {1'b0, samp[i]};
      a = t[15:0];
      o = o | t[16];
    end
    return {o, a};
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int i = 0;
    int c = 0;
    while (i < n && c < 200) begin
      chk("sready", {31'd0, sample_ready}, 32'd1);
      chk("busy_accum", {31'd0, busy}, 32'd1);
      sample_valid = toggle ? ~c[0] : 1'b1;
      sample_data  = samp[i];
      tick();
      if (sample_valid) i++;
      c++;
    end
    sample_valid = 1'b0;
  endtask

  task automatic collect(input int hold, input bit poke);
    logic [16:0] e;
    int k = 0;
    while (!result_valid && k < 50) begin
      tick();
      k++;
    end
    chk("rv_wait", {31'd0, result_valid}, 32'd1);
    if (q.size() == 0) begin
      chk("sb_empty", 32'(q.size()), 32'd1);
      e = '0;
    end else begin
      e = q[0];
    end
    for (int h = 0; h < hold; h++) begin
      sample_valid = poke;
      sample_data  = 16'hFFFF;
      chk("hold_res", {16'd0, result}, {16'd0, e[15:0]});
      chk("hold_ovf", {31'd0, result_overflow}, {31'd0, e[16]});
      chk("hold_rv", {31'd0, result_valid}, 32'd1);
      chk("done_sr", {31'd0, sample_ready}, 32'd0);
      tick();
    end
    sample_valid = 1'b0;
    result_ready = 1'b1;
    if (q.size() != 0) e = q.pop_front();
    chk("result", {16'd0, result}, {16'd0, e[15:0]});
    chk("ovf", {31'd0, result_overflow}, {31'd0, e[16]});
    tick();
    result_ready = 1'b0;
    chk("rv_drop", {31'd0, result_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("res_keep", {16'd0, result}, {16'd0, e[15:0]});
  endtask

  initial begin
    n_rst        = 1'b0;
    clear        = 1'b0;
    start        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    result_ready = 1'b0;
    start1       = 1'b0;
    sv1          = 1'b0;
    sd1          = '0;
    rr1          = 1'b0;
    tick();
    tick();
    chk("rst_sr", {31'd0, sample_ready}, 32'd0);
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    chk("rst_res", {16'd0, result}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    n_rst = 1'b1;
    tick();

    // 1: 1..8 with valid held
    for (int i = 0; i < 8; i++) samp[i] = 16'(i + 1);
    q.push_back(model(8));
    do_start();
    feed(8, 1'b0);
    chk("latency_rv", {31'd0, result_valid}, 32'd1);
    collect(0, 1'b0);

    // 2: carry out sets sticky overflow
    samp[0] = 16'hFFFF;
    samp[1] = 16'h0002;
    for (int i = 2; i < 8; i++) samp[i] = 16'h0000;
    q.push_back(model(8));
    do_start();
    feed(8, 1'b0);
    collect(0, 1'b0);

    // 3: gapped valid, stalled consumer, samples offered in DONE
    for (int i = 0; i < 8; i++) samp[i] = 16'(16'h1111 * (i + 1));
    q.push_back(model(8));
    do_start();
    feed(8, 1'b1);
    collect(5, 1'b1);

    // 4: clear mid-burst, clear beats start, fresh burst
    for (int i = 0; i < 8; i++) samp[i] = 16'h0010;
    do_start();
    feed(4, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_res", {16'd0, result}, 32'd0);
    chk("clr_sr", {31'd0, sample_ready}, 32'd0);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clr_start", {31'd0, busy}, 32'd0);
    q.push_back(model(8));
    do_start();
    feed(8, 1'b0);
    collect(0, 1'b0);

    // 5: asynchronous reset mid-burst
    for (int i = 0; i < 8; i++) samp[i] = 16'(16'h0101 * (i + 1));
    do_start();
    feed(3, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_sr", {31'd0, sample_ready}, 32'd0);
    chk("arst_rv", {31'd0, result_valid}, 32'd0);
    chk("arst_res", {16'd0, result}, 32'd0);
    chk("arst_ovf", {31'd0, result_overflow}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();
    q.push_back(model(8));
    do_start();
    feed(8, 1'b0);
    collect(0, 1'b0);

    // 6: single-sample build, start ignored outside IDLE
    start1 = 1'b1;
    tick();
    chk("n1_sr", {31'd0, sr1}, 32'd1);
    sv1 = 1'b1;
    sd1 = 16'hABCD;
    q1.push_back({1'b0, 16'hABCD});
    tick();
    sv1 = 1'b0;
    chk("n1_rv", {31'd0, rv1}, 32'd1);
    chk("n1_res", {16'd0, res1}, {15'd0, q1[0]});
    tick();
    chk("n1_hold", {31'd0, rv1}, 32'd1);
    chk("n1_busy", {31'd0, busy1}, 32'd1);
    start1 = 1'b0;
    rr1    = 1'b1;
    chk("n1_ovf", {31'd0, ovf1}, {31'd0, q1[0][16]});
    void'(q1.pop_front());
    tick();
    rr1 = 1'b0;
    chk("n1_drop", {31'd0, rv1}, 32'd0);
    chk("n1_idle", {31'd0, busy1}, 32'd0);
    chk("sb_left", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
